// File: rtl/ysyx23060136_ifu_inst_fetch.sv
// Instruction fetch stage: issues one AXI-lite style read per PC and hands the word to the IDU.
// Optional macro YSYX23060136_IFU_FAULT_EN turns a non-OKAY RRESP into an access fault carrying a NOP.
`ifndef ysyx23060136_BITS_W
`define ysyx23060136_BITS_W 32
`endif
`ifndef ysyx23060136_PC_RST
`define ysyx23060136_PC_RST 32'h8000_0000
`endif

module ysyx23060136_ifu_inst_fetch (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [`ysyx23060136_BITS_W-1:0]  IFU1_pc,
  input  logic                             BRANCH_PCSrc,
  input  logic                             FORWARD_stallID,
  output logic                             IFU_ARVALID,
  output logic [`ysyx23060136_BITS_W-1:0]  IFU_ARADDR,
  input  logic                             IFU_ARREADY,
  input  logic                             IFU_RVALID,
  output logic                             IFU_RREADY,
  input  logic [31:0]                      IFU_RDATA,
  input  logic [1:0]                       IFU_RRESP,
  output logic                             IFU_stall_req,
  output logic                             IFU2_valid,
  output logic [`ysyx23060136_BITS_W-1:0]  IFU2_pc,
  output logic [31:0]                      IFU2_inst,
  output logic                             IFU2_fault
);
  localparam int W = `ysyx23060136_BITS_W;
  localparam logic [W-1:0] PC_RST = `ysyx23060136_PC_RST;
  localparam logic [31:0]  NOP    = 32'h0000_0013;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_OUT, S_DRAIN} state_e;

  state_e        state_q;
  logic          kill_q;
  logic          arvalid_q;
  logic [W-1:0]  araddr_q;
  logic          rready_q;
  logic          valid_q;
  logic [W-1:0]  pc_q;
  logic [31:0]   inst_q;
  logic          fault_q;

  logic          accept;
  logic          cap_fault;
  logic [31:0]   cap_inst;

`ifdef YSYX23060136_IFU_FAULT_EN
  assign cap_fault = (IFU_RRESP != 2'b00);
  assign cap_inst  = cap_fault ? NOP : IFU_RDATA;
`else
  logic unused_rresp;
  assign unused_rresp = ^IFU_RRESP;
  assign cap_fault    = 1'b0;
  assign cap_inst     = IFU_RDATA;
`endif

  assign accept        = (state_q == S_OUT) && !FORWARD_stallID;
  assign IFU_stall_req = !(BRANCH_PCSrc || accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      kill_q    <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= PC_RST;
      rready_q  <= 1'b0;
      valid_q   <= 1'b0;
      pc_q      <= PC_RST;
      inst_q    <= NOP;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!BRANCH_PCSrc) begin
            araddr_q  <= IFU1_pc;
            pc_q      <= IFU1_pc;
            arvalid_q <= 1'b1;
            state_q   <= S_AR;
          end
        end
        S_AR: begin
          // The address phase is never withdrawn; a flush only marks the read for draining.
          if (IFU_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= (kill_q || BRANCH_PCSrc) ? S_DRAIN : S_R;
          end else if (BRANCH_PCSrc) begin
            kill_q <= 1'b1;
          end
        end
        S_R: begin
          if (IFU_RVALID) begin
            rready_q <= 1'b0;
            if (BRANCH_PCSrc) begin
              state_q <= S_IDLE;
            end else begin
              inst_q  <= cap_inst;
              fault_q <= cap_fault;
              valid_q <= 1'b1;
              state_q <= S_OUT;
            end
          end else if (BRANCH_PCSrc) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (IFU_RVALID) begin
            rready_q <= 1'b0;
            kill_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        S_OUT: begin
          if (BRANCH_PCSrc || !FORWARD_stallID) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign IFU_ARVALID = arvalid_q;
  assign IFU_ARADDR  = araddr_q;
  assign IFU_RREADY  = rready_q;
  assign IFU2_valid  = valid_q;
  assign IFU2_pc     = pc_q;
  assign IFU2_inst   = inst_q;
  assign IFU2_fault  = fault_q;

endmodule

// File: tb/tb_ysyx23060136_ifu_inst_fetch.sv
// Self-checking bench for the fetch stage: directed vector table, hand sequences, and a
// randomized run against an architectural-PC reference model with a simple memory slave.
`timescale 1ns/1ps
module tb_ysyx23060136_ifu_inst_fetch;
  localparam logic [31:0] PC_RST = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IFU1_pc;
  logic        BRANCH_PCSrc, FORWARD_stallID;
  logic        IFU_ARVALID, IFU_ARREADY, IFU_RVALID, IFU_RREADY;
  logic [31:0] IFU_ARADDR, IFU_RDATA;
  logic [1:0]  IFU_RRESP;
  logic        IFU_stall_req, IFU2_valid, IFU2_fault;
  logic [31:0] IFU2_pc, IFU2_inst;

  ysyx23060136_ifu_inst_fetch dut (
    .clk(clk), .rst(rst), .IFU1_pc(IFU1_pc), .BRANCH_PCSrc(BRANCH_PCSrc),
    .FORWARD_stallID(FORWARD_stallID), .IFU_ARVALID(IFU_ARVALID), .IFU_ARADDR(IFU_ARADDR),
    .IFU_ARREADY(IFU_ARREADY), .IFU_RVALID(IFU_RVALID), .IFU_RREADY(IFU_RREADY),
    .IFU_RDATA(IFU_RDATA), .IFU_RRESP(IFU_RRESP), .IFU_stall_req(IFU_stall_req),
    .IFU2_valid(IFU2_valid), .IFU2_pc(IFU2_pc), .IFU2_inst(IFU2_inst), .IFU2_fault(IFU2_fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory slave state
  bit          mem_pending;
  logic [31:0] mem_addr;
  int          ar_cnt, r_cnt, ar_dly, r_dly, reads;
  bit          rand_dly, force_en;
  logic [31:0] force_data;
  logic [1:0]  force_resp;
  logic [31:0] issued[$];
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_stall;
  logic [31:0] s_araddr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [1:0]  resp;
    int          ar_dly;
    int          r_dly;
    int          stall_n;
    int          exp_lat;
    logic [31:0] exp_inst;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return (a[5:4] == 2'b11) ? 2'd2 : 2'd0;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
`ifdef YSYX23060136_IFU_FAULT_EN
    return (mem_resp(a) != 2'd0) ? NOP : mem_word(a);
`else
    return mem_word(a);
`endif
  endfunction

  function automatic logic exp_fault(input logic [31:0] a);
`ifdef YSYX23060136_IFU_FAULT_EN
    return mem_resp(a) != 2'd0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic mem_reset();
    mem_pending = 0; ar_cnt = 0; r_cnt = 0;
    s_arvalid = 0; s_arready = 0; s_rvalid = 0; s_rready = 0;
  endtask

  // Drive slave inputs for the current cycle and sample DUT outputs mid-cycle.
  task automatic settle();
    IFU_ARREADY = IFU_ARVALID && (ar_cnt >= ar_dly);
    IFU_RVALID  = mem_pending && (r_cnt >= r_dly);
    if (IFU_RVALID) begin
      IFU_RDATA = force_en ? force_data : mem_word(mem_addr);
      IFU_RRESP = force_en ? force_resp : mem_resp(mem_addr);
    end else begin
      IFU_RDATA = $urandom;
      IFU_RRESP = 2'($urandom_range(0, 3));
    end
    #1;
    s_arvalid = IFU_ARVALID; s_arready = IFU_ARREADY; s_araddr = IFU_ARADDR;
    s_rvalid  = IFU_RVALID;  s_rready  = IFU_RREADY;  s_stall  = IFU_stall_req;
  endtask

  task automatic advance();
    @(posedge clk);
    if (s_rvalid && s_rready) mem_pending = 0;
    else if (mem_pending) r_cnt++;
    if (s_arvalid && s_arready) begin
      check("one_outstanding", 32'(mem_pending), 0);
      mem_pending = 1; mem_addr = s_araddr; issued.push_back(s_araddr);
      reads++; r_cnt = 0; ar_cnt = 0;
      if (rand_dly) begin
        r_dly  = $urandom_range(0, 3);
        ar_dly = $urandom_range(0, 3);
      end
    end else if (s_arvalid) ar_cnt++;
    else ar_cnt = 0;
    #1;
    if (s_arvalid && !s_arready && !rst) begin
      check("arvalid_hold", 32'(IFU_ARVALID), 1);
      check("araddr_hold", IFU_ARADDR, s_araddr);
    end
  endtask

  task automatic run_to_valid(input string tag, input int budget, output int lat, output int arv);
    bit done = 0;
    lat = 0; arv = 0;
    for (int k = 1; k <= budget && !done; k++) begin
      settle();
      check({tag, "_busy_stall_req"}, 32'(IFU_stall_req), 1);
      arv += int'(IFU_ARVALID);
      if (IFU2_valid) begin
        lat = k; done = 1;
      end else begin
        advance();
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: no IFU2_valid within %0d cycles", tag, budget);
    end
  endtask

  task automatic accept_one(input string tag);
    FORWARD_stallID = 0;
    settle();
    check({tag, "_accept_stall_req"}, 32'(IFU_stall_req), 0);
    advance();
    FORWARD_stallID = 1;
    settle();
    check({tag, "_post_accept_valid"}, 32'(IFU2_valid), 0);
    check({tag, "_post_accept_fault"}, 32'(IFU2_fault), 0);
  endtask

  task automatic do_reset();
    rst = 1; #1;
    mem_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  int          lat, arv, r0, accepts;
  logic [31:0] pc_ctr, tgt;
  bit          prev_hold;
  vec_t        v;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; IFU1_pc = PC_RST; BRANCH_PCSrc = 0; FORWARD_stallID = 1;
    IFU_ARREADY = 0; IFU_RVALID = 0; IFU_RDATA = 0; IFU_RRESP = 0;
    rand_dly = 0; force_en = 0; force_data = 0; force_resp = 0;
    ar_dly = 0; r_dly = 0; reads = 0;
    mem_reset();

    vecs[0] = '{32'h8000_0000, 32'h0010_0093, 2'd0, 0, 0, 0, 4, 32'h0010_0093, 1'b0};
    vecs[1] = '{32'h8000_0004, 32'h0020_0113, 2'd0, 3, 0, 0, 7, 32'h0020_0113, 1'b0};
    vecs[2] = '{32'h8000_0008, 32'h0030_0193, 2'd0, 0, 2, 5, 6, 32'h0030_0193, 1'b0};
`ifdef YSYX23060136_IFU_FAULT_EN
    vecs[3] = '{32'h8000_000C, 32'h1234_5678, 2'd2, 0, 0, 1, 4, NOP, 1'b1};
`else
    vecs[3] = '{32'h8000_000C, 32'h1234_5678, 2'd2, 0, 0, 1, 4, 32'h1234_5678, 1'b0};
`endif
    vecs[4] = '{32'h8000_0010, 32'hFFFF_FFFF, 2'd0, 1, 1, 2, 6, 32'hFFFF_FFFF, 1'b0};

    do_reset();
    settle();
    check("rst_arvalid", 32'(IFU_ARVALID), 0);
    check("rst_rready", 32'(IFU_RREADY), 0);
    check("rst_valid", 32'(IFU2_valid), 0);
    check("rst_fault", 32'(IFU2_fault), 0);
    check("rst_araddr", IFU_ARADDR, PC_RST);
    check("rst_ifu2_pc", IFU2_pc, PC_RST);
    check("rst_inst", IFU2_inst, NOP);
    check("rst_idle_stall_req", 32'(IFU_stall_req), 1);

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      IFU1_pc = v.pc; force_en = 1; force_data = v.data; force_resp = v.resp;
      ar_dly = v.ar_dly; r_dly = v.r_dly; FORWARD_stallID = 1; BRANCH_PCSrc = 0;
      r0 = reads;
      issued.delete();
      run_to_valid("vec", 40, lat, arv);
      check("vec_latency", lat, v.exp_lat);
      check("vec_arvalid_cycles", arv, v.ar_dly + 1);
      check("vec_reads", reads - r0, 1);
      if (issued.size() > 0) check("vec_araddr", issued[0], v.pc);
      check("vec_pc", IFU2_pc, v.pc);
      check("vec_inst", IFU2_inst, v.exp_inst);
      check("vec_fault", 32'(IFU2_fault), 32'(v.exp_fault));
      for (int s = 0; s < v.stall_n; s++) begin
        check("hold_stall_req", 32'(IFU_stall_req), 1);
        advance();
        settle();
        check("hold_valid", 32'(IFU2_valid), 1);
        check("hold_pc", IFU2_pc, v.pc);
        check("hold_inst", IFU2_inst, v.exp_inst);
        check("hold_no_new_read", 32'(IFU_ARVALID), 0);
      end
      accept_one("vec");
      check("vec_reads_after", reads - r0, 1);
      $display("[TB] vec %0d pc=%08h inst=%08h fault=%0d lat=%0d", i, v.pc, IFU2_inst, IFU2_fault, lat);
    end
    force_en = 0;

    // A: flush during AR before ARREADY
    ar_dly = 3; r_dly = 0; IFU1_pc = 32'h8000_0200; issued.delete();
    settle(); advance();
    settle();
    check("A_arvalid", 32'(IFU_ARVALID), 1);
    check("A_araddr", IFU_ARADDR, 32'h8000_0200);
    BRANCH_PCSrc = 1;
    settle();
    check("A_flush_stall_req", 32'(IFU_stall_req), 0);
    advance();
    BRANCH_PCSrc = 0; IFU1_pc = 32'h8000_0100;
    run_to_valid("A", 40, lat, arv);
    check("A_reads", issued.size(), 2);
    if (issued.size() == 2) begin
      check("A_wrong_addr", issued[0], 32'h8000_0200);
      check("A_next_addr", issued[1], 32'h8000_0100);
    end
    check("A_pc", IFU2_pc, 32'h8000_0100);
    check("A_inst", IFU2_inst, exp_inst(32'h8000_0100));
    accept_one("A");
    $display("[TB] seq A flush-in-AR redirected to %08h", IFU2_pc);

    // B: flush while IDLE
    ar_dly = 0; IFU1_pc = 32'h8000_0400; BRANCH_PCSrc = 1;
    settle(); advance();
    BRANCH_PCSrc = 0; IFU1_pc = 32'h8000_0300;
    settle();
    check("B_no_latch", 32'(IFU_ARVALID), 0);
    advance();
    settle();
    check("B_arvalid", 32'(IFU_ARVALID), 1);
    check("B_araddr", IFU_ARADDR, 32'h8000_0300);
    run_to_valid("B", 40, lat, arv);
    check("B_pc", IFU2_pc, 32'h8000_0300);
    accept_one("B");
    $display("[TB] seq B flush-in-IDLE latched %08h", IFU2_pc);

    // C: flush in R before RVALID -> drain
    ar_dly = 0; r_dly = 3; IFU1_pc = 32'h8000_0500; issued.delete();
    settle(); advance();
    settle(); advance();
    settle();
    check("C_rready", 32'(IFU_RREADY), 1);
    BRANCH_PCSrc = 1;
    settle(); advance();
    BRANCH_PCSrc = 0; IFU1_pc = 32'h8000_0600;
    run_to_valid("C", 40, lat, arv);
    check("C_reads", issued.size(), 2);
    if (issued.size() == 2) check("C_next_addr", issued[1], 32'h8000_0600);
    check("C_pc", IFU2_pc, 32'h8000_0600);
    check("C_inst", IFU2_inst, exp_inst(32'h8000_0600));
    accept_one("C");
    $display("[TB] seq C flush-in-R drained, delivered %08h", IFU2_pc);

    // D: flush and accept in the same OUT cycle
    r_dly = 0; IFU1_pc = 32'h8000_0700;
    run_to_valid("D", 40, lat, arv);
    check("D_latency", lat, 4);
    FORWARD_stallID = 0; BRANCH_PCSrc = 1;
    settle();
    check("D_stall_req", 32'(IFU_stall_req), 0);
    advance();
    BRANCH_PCSrc = 0; FORWARD_stallID = 1; IFU1_pc = 32'h8000_0800;
    settle();
    check("D_valid_dropped", 32'(IFU2_valid), 0);
    run_to_valid("D2", 40, lat, arv);
    check("D2_pc", IFU2_pc, 32'h8000_0800);
    accept_one("D2");
    $display("[TB] seq D flush+accept, next delivered %08h", IFU2_pc);

    // E: async reset while in R
    r_dly = 4; IFU1_pc = 32'h8000_0900;
    settle(); advance();
    settle(); advance();
    settle();
    check("E_pre_rready", 32'(IFU_RREADY), 1);
    rst = 1; #1;
    check("E_async_rready", 32'(IFU_RREADY), 0);
    check("E_async_valid", 32'(IFU2_valid), 0);
    check("E_async_arvalid", 32'(IFU_ARVALID), 0);
    mem_reset();
    repeat (2) @(posedge clk);
    #1; rst = 0;
    r_dly = 0; IFU1_pc = 32'h8000_0A00; r0 = reads;
    run_to_valid("E", 40, lat, arv);
    check("E_latency", lat, 4);
    check("E_reads", reads - r0, 1);
    check("E_pc", IFU2_pc, 32'h8000_0A00);
    // Reset again while holding a delivered instruction
    rst = 1; #1;
    check("F_async_valid", 32'(IFU2_valid), 0);
    check("F_async_inst", IFU2_inst, NOP);
    check("F_async_pc", IFU2_pc, PC_RST);
    $display("[TB] seq E/F async reset mid-transaction");
    mem_reset();
    repeat (2) @(posedge clk);
    #1; rst = 0;

    // Randomized run against the architectural PC model
    rand_dly = 1; ar_dly = 1; r_dly = 1; pc_ctr = PC_RST; accepts = 0; prev_hold = 0;
    for (int c = 0; c < 2000; c++) begin
      FORWARD_stallID = ($urandom_range(0, 9) < 3);
      BRANCH_PCSrc    = ($urandom_range(0, 99) < 6);
      tgt = {16'h8000, 14'($urandom), 2'b00};
      IFU1_pc = pc_ctr;
      settle();
      check("rnd_stall_req", 32'(IFU_stall_req),
            32'(!(BRANCH_PCSrc || (IFU2_valid && !FORWARD_stallID))));
      if (prev_hold) check("rnd_hold_valid", 32'(IFU2_valid), 1);
      if (IFU2_valid) begin
        check("rnd_pc", IFU2_pc, pc_ctr);
        check("rnd_inst", IFU2_inst, exp_inst(pc_ctr));
        check("rnd_fault", 32'(IFU2_fault), 32'(exp_fault(pc_ctr)));
        if (!FORWARD_stallID && !BRANCH_PCSrc) begin
          accepts++;
          $display("[TB] rnd accept pc=%08h inst=%08h fault=%0d", IFU2_pc, IFU2_inst, IFU2_fault);
        end
      end
      prev_hold = IFU2_valid && FORWARD_stallID && !BRANCH_PCSrc;
      advance();
      if (BRANCH_PCSrc) pc_ctr = tgt;
      else if (!s_stall) pc_ctr = pc_ctr + 32'd4;
    end
    check("rnd_progress", 32'(accepts >= 40), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx23060136_ifu_inst_fetch.md
YSYX23060136_IFU_INST_FETCH -- requirements
Module: ysyx23060136_IFU_INST_FETCH

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 SHALL have the following ports (W = `ysyx23060136_BITS_W):
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- IFU1_pc  input  W  current PC from the IFU1 PC counter
- BRANCH_PCSrc  input  1  redirect/flush: fetched or in-flight instruction is wrong-path
- FORWARD_stallID  input  1  IDU cannot accept this cycle
- IFU_ARVALID  output  1  instruction read address valid
- IFU_ARADDR  output  W  read address (latched PC)
- IFU_ARREADY  input  1  memory accepts address
- IFU_RVALID  input  1  read data valid
- IFU_RREADY  output  1  IFU accepts read data
- IFU_RDATA  input  32  instruction word
- IFU_RRESP  input  2  read response, 0 = OKAY
- IFU_stall_req  output  1  hold the PC counter (feeds FORWARD_stallIF)
- IFU2_valid  output  1  IFU2_inst/IFU2_pc hold a valid instruction
- IFU2_pc  output  W  PC of the delivered instruction
- IFU2_inst  output  32  delivered instruction
- IFU2_fault  output  1  access fault on the delivered instruction

Function
REQ-003 SHALL implement an FSM with states IDLE, AR, R, OUT and DRAIN, plus a 1-bit kill flag.
REQ-004 IDLE, no flush: SHALL latch IFU1_pc into IFU_ARADDR and IFU2_pc, then go to AR on the next edge.
REQ-005 AR: SHALL drive IFU_ARVALID=1 with IFU_ARADDR held stable. On IFU_ARREADY=1: go to DRAIN if kill=1 or BRANCH_PCSrc=1, else go to R.
REQ-006 SHALL NOT drop IFU_ARVALID before IFU_ARREADY, even on flush. A flush in AR without IFU_ARREADY sets kill.
REQ-007 R: SHALL drive IFU_RREADY=1. On IFU_RVALID=1 without flush: register IFU_RDATA into IFU2_inst, set IFU2_valid=1, go to OUT. On IFU_RVALID=1 with flush: discard data, go to IDLE. Flush without IFU_RVALID: go to DRAIN.
REQ-008 DRAIN: SHALL drive IFU_RREADY=1 and discard data. On IFU_RVALID=1: clear kill, go to IDLE.
REQ-009 OUT: SHALL hold IFU2_valid, IFU2_pc and IFU2_inst stable while FORWARD_stallID=1. Accept (FORWARD_stallID=0) or flush: clear IFU2_valid, go to IDLE.
REQ-010 IFU_stall_req SHALL be 0 only in the OUT accept cycle or in any cycle with BRANCH_PCSrc=1; it SHALL be 1 otherwise, including in IDLE.
REQ-011 Flush and accept in the same OUT cycle: flush wins and the instruction is dropped; IFU2_valid goes to 0 either way.
REQ-012 Flush in IDLE: SHALL remain in IDLE without latching; the redirected PC is latched the following cycle.
REQ-013 Latency with zero-wait memory: 3 cycles from IDLE to IFU2_valid=1 (IDLE, AR, R, then OUT). Throughput is at most one instruction per 4 cycles.
REQ-014 IFU_ARVALID, IFU_RREADY and IFU2_valid SHALL be registered. At most one read SHALL be outstanding at any time.

Reset
REQ-015 rst=1 SHALL, asynchronously:
- set the state to IDLE and clear kill
- drive IFU_ARVALID=0, IFU_RREADY=0, IFU2_valid=0, IFU2_fault=0
- set IFU_ARADDR and IFU2_pc to `ysyx23060136_PC_RST, and IFU2_inst to 32'h00000013
REQ-016 Reset mid-transaction SHALL abandon it with no further handshakes. The memory side shares rst.

Configuration
REQ-017 With YSYX23060136_IFU_FAULT_EN defined: IFU_RRESP!=0 on capture SHALL set IFU2_fault=1 and load IFU2_inst=32'h00000013. Fault is cleared with IFU2_valid.
REQ-018 Without YSYX23060136_IFU_FAULT_EN: IFU_RRESP SHALL be ignored, IFU2_fault tied to 0, and IFU_RDATA always captured.

Verification
REQ-019 Zero-wait memory, PC=0x80000000, RDATA=0x00100093 -> IFU2_valid on the 4th cycle after reset release, IFU2_pc=0x80000000, IFU2_inst=0x00100093, stall_req=0 only in the accept cycle.
REQ-020 ARREADY delayed 3 cycles -> ARVALID=1 and ARADDR stable for 4 cycles; exactly one read issued.
REQ-021 BRANCH_PCSrc pulse in AR before ARREADY, target 0x80000100 -> wrong-path read drained, no IFU2_valid, next ARADDR=0x80000100.
REQ-022 FORWARD_stallID=1 for 5 cycles in OUT -> outputs stable, stall_req=1, PC held; release -> one accept.
REQ-023 With FAULT_EN: RRESP=2 -> IFU2_fault=1, IFU2_inst=0x00000013. Without FAULT_EN: same stimulus gives fault=0 and RDATA passed through.
REQ-024 rst asserted while in R -> RREADY=0 and IFU2_valid=0 immediately, without waiting for a clock edge.
